// File: rtl/regfile_writeback.sv
// Register-file writeback queue: merges load and ALU results into an in-order FIFO and
// drains one write per cycle. Define WB_FORWARD_EN to compile in read-index forwarding.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [1:0]  mem_addr,
  input  logic [15:0] mem_data,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [1:0]  alu_addr,
  input  logic [15:0] alu_data,
  input  logic        wb_hold,
  output logic        reg_write,
  output logic [1:0]  wr_addr,
  output logic [15:0] wr_data,
  input  logic [1:0]  rd_addr_1,
  input  logic [1:0]  rd_addr_2,
  output logic        fwd_hit_1,
  output logic        fwd_hit_2,
  output logic [15:0] fwd_data_1,
  output logic [15:0] fwd_data_2,
  output logic [3:0]  pending,
  output logic [3:0]  level
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [1:0]  addr;
    logic [15:0] data;
  } wb_entry_t;

  wb_entry_t         ent_q [DEPTH];
  wb_entry_t         push_ent, head;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]        level_q, level_d;
  logic              full, push, pop, nonempty;

  assign full      = (level_q == 4'(DEPTH));
  assign nonempty  = (level_q != 4'd0);
  assign mem_ready = !full;
  assign alu_ready = !full && !mem_valid;
  assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
  assign push_ent  = mem_valid ? {mem_addr, mem_data} : {alu_addr, alu_data};
  assign head      = ent_q[rd_ptr_q];
  assign pop       = nonempty && !wb_hold;

  assign reg_write = pop;
  assign wr_addr   = nonempty ? head.addr : 2'd0;
  assign wr_data   = nonempty ? head.data : 16'd0;
  assign level     = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q + 4'(push) - 4'(pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left unreset; every read below is qualified by level_q.
  always_ff @(posedge clk) begin
    if (reset && push) ent_q[wr_ptr_q] <= push_ent;
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) < level_q) pending[ent_q[rd_ptr_q + PW'(i)].addr] = 1'b1;
    end
  end

`ifdef WB_FORWARD_EN
  // Walk oldest to youngest so the last match is the youngest write.
  always_comb begin
    fwd_hit_1  = 1'b0;
    fwd_hit_2  = 1'b0;
    fwd_data_1 = '0;
    fwd_data_2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (4'(i) < level_q) begin
        if (ent_q[rd_ptr_q + PW'(i)].addr == rd_addr_1) begin
          fwd_hit_1  = 1'b1;
          fwd_data_1 = ent_q[rd_ptr_q + PW'(i)].data;
        end
        if (ent_q[rd_ptr_q + PW'(i)].addr == rd_addr_2) begin
          fwd_hit_2  = 1'b1;
          fwd_data_2 = ent_q[rd_ptr_q + PW'(i)].data;
        end
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd  = ^{rd_addr_1, rd_addr_2};
  assign fwd_hit_1  = 1'b0;
  assign fwd_hit_2  = 1'b0;
  assign fwd_data_1 = '0;
  assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed vector table plus a randomized phase,
// both checked against a queue model of the writeback FIFO.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid, wb_hold;
  logic        mem_ready, alu_ready, reg_write;
  logic [1:0]  mem_addr, alu_addr, wr_addr, rd_addr_1, rd_addr_2;
  logic [15:0] mem_data, alu_data, wr_data;
  logic        fwd_hit_1, fwd_hit_2;
  logic [15:0] fwd_data_1, fwd_data_2;
  logic [3:0]  pending, level;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .wb_hold(wb_hold), .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .fwd_hit_1(fwd_hit_1), .fwd_hit_2(fwd_hit_2),
    .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2),
    .pending(pending), .level(level)
  );

  typedef struct {
    logic        chk, rst, mv, av, hold;
    logic [1:0]  ma, aa;
    logic [15:0] md, ad;
    logic        rw, mr, ar, fh1;
    logic [1:0]  wa;
    logic [15:0] wd, fd1;
    logic [3:0]  lvl, pend;
  } vec_t;

  typedef logic [17:0] ent_t;
  ent_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t tbl[33];

  function automatic vec_t mk(logic rst, logic mv, logic [1:0] ma, logic [15:0] md,
                              logic av, logic [1:0] aa, logic [15:0] ad, logic hold,
                              logic rw, logic [1:0] wa, logic [15:0] wd, logic [3:0] lvl,
                              logic [3:0] pend, logic mr, logic ar);
    vec_t v;
    v.chk = 1'b1; v.rst = rst; v.mv = mv; v.ma = ma; v.md = md;
    v.av = av; v.aa = aa; v.ad = ad; v.hold = hold;
    v.rw = rw; v.wa = wa; v.wd = wd; v.lvl = lvl; v.pend = pend;
    v.mr = mr; v.ar = ar; v.fh1 = 1'b0; v.fd1 = 16'h0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every output with what the queue model predicts for this cycle.
  task automatic model_check(input string tag);
    int          n;
    logic [3:0]  e_pend;
    logic        e_h1, e_h2;
    logic [15:0] e_d1, e_d2;
    n = sb.size();
    e_pend = '0; e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
    foreach (sb[i]) begin
      e_pend[sb[i][17:16]] = 1'b1;
      if (sb[i][17:16] == rd_addr_1) begin e_h1 = 1'b1; e_d1 = sb[i][15:0]; end
      if (sb[i][17:16] == rd_addr_2) begin e_h2 = 1'b1; e_d2 = sb[i][15:0]; end
    end
`ifndef WB_FORWARD_EN
    e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = '0; e_d2 = '0;
`endif
    chk({tag, " level"}, 32'(level), 32'(n));
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(n < DEPTH));
    chk({tag, " alu_ready"}, 32'(alu_ready), 32'(n < DEPTH && !mem_valid));
    chk({tag, " reg_write"}, 32'(reg_write), 32'(n > 0 && !wb_hold));
    chk({tag, " pending"}, 32'(pending), 32'(e_pend));
    chk({tag, " fwd1"}, {15'd0, fwd_hit_1, fwd_data_1}, {15'd0, e_h1, e_d1});
    chk({tag, " fwd2"}, {15'd0, fwd_hit_2, fwd_data_2}, {15'd0, e_h2, e_d2});
    if (n == 0) chk({tag, " wr_empty"}, {14'd0, wr_addr, wr_data}, 32'd0);
    else if (!wb_hold) chk({tag, " wr_head"}, {14'd0, wr_addr, wr_data}, {14'd0, sb[0]});
  endtask

  // Advance the model across one rising edge using the inputs held on it.
  task automatic model_edge();
    bit full, pop_now;
    full    = sb.size() >= DEPTH;
    pop_now = sb.size() > 0 && !wb_hold;
    if (!reset) sb.delete();
    else begin
      if (pop_now) void'(sb.pop_front());
      if (mem_valid && !full) sb.push_back({mem_addr, mem_data});
      else if (alu_valid && !full && !mem_valid) sb.push_back({alu_addr, alu_data});
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    logic  e_h1;
    logic [15:0] e_d1;
    tag = $sformatf("row%0d", idx);
    reset = v.rst; mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad; wb_hold = v.hold;
    rd_addr_1 = 2'd0; rd_addr_2 = 2'd3;
    @(negedge clk);
    if (v.chk) begin
      e_h1 = v.fh1; e_d1 = v.fd1;
`ifndef WB_FORWARD_EN
      e_h1 = 1'b0; e_d1 = '0;
`endif
      chk({tag, " t_reg_write"}, 32'(reg_write), 32'(v.rw));
      chk({tag, " t_level"}, 32'(level), 32'(v.lvl));
      chk({tag, " t_pending"}, 32'(pending), 32'(v.pend));
      chk({tag, " t_readies"}, {30'd0, mem_ready, alu_ready}, {30'd0, v.mr, v.ar});
      chk({tag, " t_fwd1"}, {15'd0, fwd_hit_1, fwd_data_1}, {15'd0, e_h1, e_d1});
      if (v.rw || v.lvl == 4'd0)
        chk({tag, " t_wr"}, {14'd0, wr_addr, wr_data}, {14'd0, v.wa, v.wd});
      model_check(tag);
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0; wb_hold = 1'b0;
    mem_addr = '0; mem_data = '0; alu_addr = '0; alu_data = '0;
    rd_addr_1 = '0; rd_addr_2 = '0;
    //            rst mv ma md       av aa ad       hold rw wa wd       lvl pend     mr ar
    tbl[0]  = mk(0, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[0].chk = 1'b0;
    tbl[1]  = mk(1, 0, 0, 16'h0,    1, 2, 16'h1234, 0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[2]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 2, 16'h1234, 1, 4'b0100, 1, 1);
    tbl[3]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[4]  = mk(1, 1, 1, 16'hAAAA, 1, 3, 16'h5555, 1,  0, 0, 16'h0,    0, 4'b0000, 1, 0);
    tbl[5]  = mk(1, 0, 0, 16'h0,    1, 3, 16'h5555, 1,  0, 0, 16'h0,    1, 4'b0010, 1, 1);
    tbl[6]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 1, 16'hAAAA, 2, 4'b1010, 1, 1);
    tbl[7]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 3, 16'h5555, 1, 4'b1000, 1, 1);
    tbl[8]  = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[9]  = mk(1, 0, 0, 16'h0,    1, 0, 16'h0100, 1,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[10] = mk(1, 0, 0, 16'h0,    1, 1, 16'h0101, 1,  0, 0, 16'h0,    1, 4'b0001, 1, 1);
    tbl[11] = mk(1, 0, 0, 16'h0,    1, 2, 16'h0102, 1,  0, 0, 16'h0,    2, 4'b0011, 1, 1);
    tbl[12] = mk(1, 0, 0, 16'h0,    1, 3, 16'h0103, 1,  0, 0, 16'h0,    3, 4'b0111, 1, 1);
    tbl[13] = mk(1, 0, 0, 16'h0,    1, 0, 16'h0BAD, 1,  0, 0, 16'h0,    4, 4'b1111, 0, 0);
    tbl[14] = mk(1, 1, 2, 16'h0BEE, 0, 0, 16'h0,    1,  0, 0, 16'h0,    4, 4'b1111, 0, 0);
    tbl[15] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 0, 16'h0100, 4, 4'b1111, 0, 0);
    tbl[16] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 1, 16'h0101, 3, 4'b1110, 1, 1);
    tbl[17] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 2, 16'h0102, 2, 4'b1100, 1, 1);
    tbl[18] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 3, 16'h0103, 1, 4'b1000, 1, 1);
    tbl[19] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[20] = mk(1, 0, 0, 16'h0,    1, 0, 16'h0001, 1,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[21] = mk(1, 0, 0, 16'h0,    1, 0, 16'h0002, 1,  0, 0, 16'h0,    1, 4'b0001, 1, 1);
    tbl[22] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    1,  0, 0, 16'h0,    2, 4'b0001, 1, 1);
    tbl[23] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 0, 16'h0001, 2, 4'b0001, 1, 1);
    tbl[24] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 0, 16'h0002, 1, 4'b0001, 1, 1);
    tbl[25] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[26] = mk(1, 0, 0, 16'h0,    1, 1, 16'h0011, 1,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[27] = mk(1, 0, 0, 16'h0,    1, 2, 16'h0022, 1,  0, 0, 16'h0,    1, 4'b0010, 1, 1);
    tbl[28] = mk(1, 0, 0, 16'h0,    1, 3, 16'h0033, 1,  0, 0, 16'h0,    2, 4'b0110, 1, 1);
    tbl[29] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  1, 1, 16'h0011, 3, 4'b1110, 1, 1);
    tbl[30] = mk(0, 0, 0, 16'h0,    1, 0, 16'h0FFF, 0,  1, 2, 16'h0022, 2, 4'b1100, 1, 1);
    tbl[31] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    tbl[32] = mk(1, 0, 0, 16'h0,    0, 0, 16'h0,    0,  0, 0, 16'h0,    0, 4'b0000, 1, 1);
    // r0 forwarding visible through rd_addr_1 = 0 (youngest r0 entry wins).
    for (int r = 10; r <= 15; r++) begin tbl[r].fh1 = 1'b1; tbl[r].fd1 = 16'h0100; end
    tbl[21].fh1 = 1'b1; tbl[21].fd1 = 16'h0001;
    for (int r = 22; r <= 24; r++) begin tbl[r].fh1 = 1'b1; tbl[r].fd1 = 16'h0002; end

    #1;
    for (int i = 0; i < 33; i++) apply(tbl[i], i);

    // Randomized traffic with occasional resets, checked purely against the model.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 39) != 0);
      mem_valid = ($urandom_range(0, 2) == 0);
      alu_valid = ($urandom_range(0, 1) == 0);
      wb_hold   = ($urandom_range(0, 2) == 0);
      mem_addr  = 2'($urandom_range(0, 3));
      alu_addr  = 2'($urandom_range(0, 3));
      mem_data  = 16'($urandom);
      alu_data  = 16'($urandom);
      rd_addr_1 = 2'($urandom_range(0, 3));
      rd_addr_2 = 2'($urandom_range(0, 3));
      @(negedge clk);
      model_check($sformatf("rand%0d", c));
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
